cmp_pipe: RTL

//  Pipelined, parametrised successor to the branch comparator. Evaluates one compare op per accepted

---
 rtl/cmp_pipe.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/cmp_pipe.sv
// Purpose: pipelined A/B comparator (zero tests, equality, signed/unsigned magnitude) with tag pass-through; `CMP_STATS_EN adds result counters.
// Latency: STAGES cycles (1 or 2) from request accept to out_valid; sustains one result per cycle.
// Backpressure: out_ready low holds the result stable and fills the pipe; in_ready drops when full or during flush.
module cmp_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_func,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_y,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
`ifdef CMP_STATS_EN
  ,
  output logic [31:0]      stat_total,
  output logic [31:0]      stat_true
`endif
);

  // Returns {err, y}; undefined codes give y=0, err=1.
  function automatic logic [1:0] cmp_eval(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic [3:0]       func);
    logic a_neg;
    logic a_zero;
    logic slt;
    logic ult;
    logic y;
    logic err;
    a_neg  = a[WIDTH-1];
    a_zero = (a == '0);
    slt    = ($signed(a) < $signed(b));
    ult    = (a < b);
    y      = 1'b0;
    err    = 1'b0;
    case (func)
      4'd0:    y = !a_neg && !a_zero;
      4'd1:    y = !a_neg;
      4'd2:    y = a_neg;
      4'd3:    y = a_neg || a_zero;
      4'd4:    y = (a == b);
      4'd5:    y = (a != b);
      4'd6:    y = slt;
      4'd7:    y = ult;
      4'd8:    y = !slt;
      4'd9:    y = !ult;
      default: err = 1'b1;
    endcase
    return {err, y};
  endfunction

  logic             last_v;
  logic             res_y;
  logic             res_err;
  logic [TAG_W-1:0] res_tag;
  logic             accept;
  logic             drain;

  assign accept = in_valid && in_ready;
  assign drain  = last_v && out_ready;

  if (STAGES == 1) begin : g_one
    logic             v_q, v_d;
    logic             y_q, y_d;
    logic             err_q, err_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [1:0]       ev;

    assign ev       = cmp_eval(in_a, in_b, in_func);
    assign in_ready = !flush && (!v_q || out_ready);

    // Result slot: load on accept, clear on drain or flush, otherwise hold.
    always_comb begin
      v_d   = v_q;
      y_d   = y_q;
      err_d = err_q;
      tag_d = tag_q;
      if (flush) begin
        v_d = 1'b0;
      end else if (accept) begin
        v_d   = 1'b1;
        y_d   = ev[0];
        err_d = ev[1];
        tag_d = in_tag;
      end else if (drain) begin
        v_d = 1'b0;
      end
    end

    // Result slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        y_q   <= 1'b0;
        err_q <= 1'b0;
        tag_q <= '0;
      end else begin
        v_q   <= v_d;
        y_q   <= y_d;
        err_q <= err_d;
        tag_q <= tag_d;
      end
    end

    assign last_v  = v_q;
    assign res_y   = y_q;
    assign res_err = err_q;
    assign res_tag = tag_q;
  end else if (STAGES == 2) begin : g_two
    logic             v0_q, v0_d;
    logic [WIDTH-1:0] a0_q, a0_d;
    logic [WIDTH-1:0] b0_q, b0_d;
    logic [3:0]       f0_q, f0_d;
    logic [TAG_W-1:0] t0_q, t0_d;
    logic             v1_q, v1_d;
    logic             y1_q, y1_d;
    logic             e1_q, e1_d;
    logic [TAG_W-1:0] t1_q, t1_d;
    logic             adv0;
    logic [1:0]       ev;

    assign ev       = cmp_eval(a0_q, b0_q, f0_q);
    assign adv0     = v0_q && (!v1_q || out_ready);
    assign in_ready = !flush && (!v0_q || adv0);

    // Slot0 holds operands, slot1 the evaluated result; each moves only when downstream frees.
    always_comb begin
      v0_d = v0_q;
      a0_d = a0_q;
      b0_d = b0_q;
      f0_d = f0_q;
      t0_d = t0_q;
      v1_d = v1_q;
      y1_d = y1_q;
      e1_d = e1_q;
      t1_d = t1_q;
      if (flush) begin
        v0_d = 1'b0;
        v1_d = 1'b0;
      end else begin
        if (adv0) begin
          v1_d = 1'b1;
          y1_d = ev[0];
          e1_d = ev[1];
          t1_d = t0_q;
        end else if (drain) begin
          v1_d = 1'b0;
        end
        if (accept) begin
          v0_d = 1'b1;
          a0_d = in_a;
          b0_d = in_b;
          f0_d = in_func;
          t0_d = in_tag;
        end else if (adv0) begin
          v0_d = 1'b0;
        end
      end
    end

    // Two-slot pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v0_q <= 1'b0;
        a0_q <= '0;
        b0_q <= '0;
        f0_q <= '0;
        t0_q <= '0;
        v1_q <= 1'b0;
        y1_q <= 1'b0;
        e1_q <= 1'b0;
        t1_q <= '0;
      end else begin
        v0_q <= v0_d;
        a0_q <= a0_d;
        b0_q <= b0_d;
        f0_q <= f0_d;
        t0_q <= t0_d;
        v1_q <= v1_d;
        y1_q <= y1_d;
        e1_q <= e1_d;
        t1_q <= t1_d;
      end
    end

    assign last_v  = v1_q;
    assign res_y   = y1_q;
    assign res_err = e1_q;
    assign res_tag = t1_q;
  end else begin : g_bad
    $error("cmp_pipe: STAGES must be 1 or 2");
  end

  // Outputs forced to zero whenever no result is presented.
  assign out_valid = last_v;
  assign out_y     = last_v && res_y;
  assign out_err   = last_v && res_err;
  assign out_tag   = last_v ? res_tag : '0;

`ifdef CMP_STATS_EN
  logic [31:0] total_q, total_d;
  logic [31:0] true_q, true_d;

  // Saturating counts of consumed results; flush does not touch them.
  always_comb begin
    total_d = total_q;
    true_d  = true_q;
    if (drain) begin
      if (total_q != 32'hFFFF_FFFF) total_d = total_q + 32'd1;
      if (res_y && (true_q != 32'hFFFF_FFFF)) true_d = true_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
      true_q  <= '0;
    end else begin
      total_q <= total_d;
      true_q  <= true_d;
    end
  end

  assign stat_total = total_q;
  assign stat_true  = true_q;
`endif

endmodule
